ntt_sched: RTL
==============

// Module: ntt_sched
// PURPOSE
//  Sequencer for one dual-pipelined NTT instance. On a start pulse it:
//   - reads a polynomial from a two-read-port coefficient RAM;
//   - streams PAIRS coefficient pairs (a[k], a[k+PAIRS]) into the NTT as one contiguous in_en burst;
//   - collects the PAIRS output pairs into a pair-wide result RAM;
//   - pulses done when the transform is complete.
//  It also owns the free-running fifo1_addr rotation that every NTT stage's sio_ram shares.
// PARAMETERS
//  DW        12    coefficient width (matches `DATA_WIDTH)
//  PAIRS     128   butterfly pairs per transform (N/2)
//  AW        $clog2(PAIRS)   pair-address width (derived)
//  MUL_LAT   3     mo_mul pipeline depth (matches `MUL_STAGE_CNT); fifo1_addr modulus
//  FAW       $clog2(DW)      fifo1_addr width (matches NTT port)
//  TIMEOUT   1024  max cycles in DRAIN without completing before abort
// PORTS
//  clk         in   1      clock
//  rst         in   1      async reset, active high
//  start       in   1      launch transform; honoured only in IDLE
//  busy        out  1      high in FEED and DRAIN
//  done        out  1      one-cycle pulse at end of transform (normal or abort)
//  err         out  1      sticky: timeout or excess out_en; cleared by accepted start
//  rd_en       out  1      coefficient RAM read strobe
//  rd_addr0    out  AW+1   read address, low half (k)
//  rd_addr1    out  AW+1   read address, high half (k+PAIRS)
//  rd_data0    in   DW     read data port 0, valid 1 cycle after rd_en
//  rd_data1    in   DW     read data port 1, valid 1 cycle after rd_en
//  ntt_in_en   out  1      NTT in_en
//  ntt_in0     out  DW     NTT in[0] (= rd_data0)
//  ntt_in1     out  DW     NTT in[1] (= rd_data1)
//  ntt_out_en  in   1      NTT out_en
//  ntt_out0    in   DW     NTT out[0]
//  ntt_out1    in   DW     NTT out[1]
//  wr_en       out  1      result RAM write strobe
//  wr_addr     out  AW     result pair address
//  wr_data     out  2*DW   {ntt_out1, ntt_out0}
//  fifo1_addr  out  FAW    shared sio_ram address to all NTT stages
// BEHAVIOUR
//  Reset values: every output 0; FSM in IDLE; all counters 0.
//  fifo1_addr: free-running from reset, 0,1,..,MUL_LAT-1,0,...; advances every cycle regardless of state.
//  FSM IDLE -> FEED -> DRAIN -> DONE -> IDLE.
//  IDLE:
//   - start=1: clear err, clear rd_cnt and wr_cnt, go to FEED.
//   - Any other input is ignored, including start in FEED, DRAIN and DONE.
//  FEED:
//   - rd_en=1, rd_addr0=rd_cnt, rd_addr1=rd_cnt+PAIRS, rd_cnt++ each cycle.
//   - Leaves to DRAIN after the cycle with rd_cnt==PAIRS-1. This gives exactly PAIRS consecutive reads.
//  ntt_in_en is rd_en delayed by one register. ntt_in0/1 are rd_data0/1 passed combinationally.
//   - Result: start accepted at cycle T gives reads at T+1..T+PAIRS and in_en high T+2..T+PAIRS+1, with no gaps.
//  Write path, active in FEED and DRAIN:
//   - wr_en=ntt_out_en, wr_addr=wr_cnt, wr_data={ntt_out1, ntt_out0}, all combinational.
//   - wr_cnt++ on each write.
//  DRAIN completes on the write with wr_cnt==PAIRS-1; the next state is DONE.
//  DONE lasts one cycle: done=1, busy=0. It then returns to IDLE.
//  Excess output:
//   - ntt_out_en high in DONE or IDLE means the NTT produced more than PAIRS outputs.
//   - Response: set err and suppress wr_en.
//  Timeout:
//   - A DRAIN cycle counter saturates at TIMEOUT.
//   - Reaching TIMEOUT before completion sets err and goes to DONE (done pulses). Writes already made are kept.
//  Output writes may overlap FEED; no ordering is assumed beyond the count.
//  Async rst at any time:
//   - Immediate return to IDLE with outputs 0; the in-flight transform is lost.
//   - The NTT is reset by the same rst.
// TESTING
//  1. Reset, then idle 7 cycles -> all outputs 0; fifo1_addr 1,2,0,1,2,0,1 (MUL_LAT=3).
//  2. start at T=10, NTT model latency 20:
//     - rd_addr0 0..127 / rd_addr1 128..255 at 11..138;
//     - in_en 12..139;
//     - 128 writes addr 0..127;
//     - done 1 cycle after last write; err=0.
//  3. start held high continuously -> ignored while busy; second transform begins 1 cycle after DONE; wr_addr restarts at 0.
//  4. NTT model never raises out_en -> err=1, done pulse TIMEOUT cycles after DRAIN entry, then busy=0.
//  5. Model emits 129 out_en cycles -> exactly 128 writes, err=1 after 129th; next start clears err.
//  6. rst asserted mid-FEED (rd_cnt=50) -> outputs 0 same cycle; later start reads from addr 0 and completes normally.

Source files
------------

// File: rtl/ntt_sched_if.sv
// Handshake/bus bundle between the NTT sequencer, its coefficient/result RAMs and the NTT core.
interface ntt_sched_if #(
    parameter int DW    = 12,
    parameter int PAIRS = 128,
    parameter int AW    = $clog2(PAIRS),
    parameter int FAW   = $clog2(DW)
);
    logic            start;
    logic            busy;
    logic            done;
    logic            err;
    logic            rd_en;
    logic [AW:0]     rd_addr0;
    logic [AW:0]     rd_addr1;
    logic [DW-1:0]   rd_data0;
    logic [DW-1:0]   rd_data1;
    logic            ntt_in_en;
    logic [DW-1:0]   ntt_in0;
    logic [DW-1:0]   ntt_in1;
    logic            ntt_out_en;
    logic [DW-1:0]   ntt_out0;
    logic [DW-1:0]   ntt_out1;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [FAW-1:0]  fifo1_addr;

    modport master (
        input  start, rd_data0, rd_data1, ntt_out_en, ntt_out0, ntt_out1,
        output busy, done, err, rd_en, rd_addr0, rd_addr1,
               ntt_in_en, ntt_in0, ntt_in1, wr_en, wr_addr, wr_data, fifo1_addr
    );

    modport slave (
        output start, rd_data0, rd_data1, ntt_out_en, ntt_out0, ntt_out1,
        input  busy, done, err, rd_en, rd_addr0, rd_addr1,
               ntt_in_en, ntt_in0, ntt_in1, wr_en, wr_addr, wr_data, fifo1_addr
    );
endinterface

// File: rtl/ntt_sched.sv
// Sequencer for one dual-pipelined NTT: feeds PAIRS coefficient pairs, collects PAIRS results,
// and drives the shared fifo1_addr rotation for every NTT stage.
module ntt_sched #(
    parameter int DW      = 12,
    parameter int PAIRS   = 128,
    parameter int AW      = $clog2(PAIRS),
    parameter int MUL_LAT = 3,
    parameter int FAW     = $clog2(DW),
    parameter int TIMEOUT = 1024
) (
    input logic          clk,
    input logic          rst,
    ntt_sched_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t         state;
    logic [AW-1:0]  rd_cnt;
    logic [AW:0]    wr_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic           err_q;
    logic           in_en_q;
    logic [FAW-1:0] fifo_q;

    logic feed, drain, active, wr_ok, wr_last, excess;

    assign feed   = (state == FEED);
    assign drain  = (state == DRAIN);
    assign active = feed | drain;
    // wr_cnt[AW] marks a full result buffer; anything beyond that is an excess output
    assign wr_ok   = bus.ntt_out_en & active & ~wr_cnt[AW];
    assign wr_last = wr_ok & (wr_cnt == (AW+1)'(PAIRS - 1));
    assign excess  = bus.ntt_out_en & ~wr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
            in_en_q <= 1'b0;
            fifo_q  <= '0;
        end else begin
            fifo_q  <= (fifo_q == FAW'(MUL_LAT - 1)) ? '0 : fifo_q + 1'b1;
            in_en_q <= feed;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= FEED;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        err_q  <= 1'b0;
                    end else if (excess) begin
                        err_q <= 1'b1;
                    end
                end
                FEED: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == AW'(PAIRS - 1)) begin
                        state   <= DRAIN;
                        tmo_cnt <= '0;
                    end
                    if (wr_ok)  wr_cnt <= wr_cnt + 1'b1;
                    if (excess) err_q  <= 1'b1;
                end
                DRAIN: begin
                    if (wr_ok)  wr_cnt <= wr_cnt + 1'b1;
                    if (excess) err_q  <= 1'b1;
                    if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
                    // all results may already be in if the NTT finished during FEED
                    if (wr_last || wr_cnt[AW]) begin
                        state <= DONE;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (excess) err_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = active;
    assign bus.done       = (state == DONE);
    assign bus.err        = err_q;
    assign bus.rd_en      = feed;
    assign bus.rd_addr0   = feed ? {1'b0, rd_cnt} : '0;
    assign bus.rd_addr1   = feed ? {1'b1, rd_cnt} : '0;
    assign bus.ntt_in_en  = in_en_q;
    assign bus.ntt_in0    = bus.rd_data0;
    assign bus.ntt_in1    = bus.rd_data1;
    assign bus.wr_en      = wr_ok;
    assign bus.wr_addr    = wr_cnt[AW-1:0];
    assign bus.wr_data    = {bus.ntt_out1, bus.ntt_out0};
    assign bus.fifo1_addr = fifo_q;
endmodule
